// File: rtl/seq_sub64_pkg.sv
// Shared definitions for the sequential 64-bit subtractor.
//   state_e : controller states (IDLE / RUN / DONE)
//   WORD    : operand and result width
package seq_sub64_pkg;

  localparam int unsigned WORD = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_sub64_sub_chunk.sv
// sub_chunk: combinational W-bit borrow-ripple subtractor, d = x - y - bi.
//   x, y : operand slices
//   bi   : borrow into bit 0
//   d    : difference slice
//   bo   : borrow out of the top bit
module sub_chunk #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);

  logic borrow;

  always_comb begin
    d      = '0;
    borrow = bi;
    for (int unsigned i = 0; i < W; i++) begin
      d[i]   = x[i] ^ y[i] ^ borrow;
      // Borrow when x < y + borrow at this bit position.
      borrow = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & borrow);
    end
    bo = borrow;
  end

endmodule

// File: rtl/seq_sub64.sv
// seq_sub64: multi-cycle 64-bit subtractor, diff = a - b - bin (mod 2^64),
// one CHUNK-bit slice per clock, LSB slice first.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : launch request, accepted in IDLE or DONE
//   a, b, bin: operands, latched when start is accepted
//   busy     : high while slices are being processed
//   done     : one-cycle pulse, diff/bout valid
//   diff     : difference, held until the next accepted start
//   bout     : borrow-out (a < b + bin, unsigned)
module seq_sub64
  import seq_sub64_pkg::*;
#(
  parameter int unsigned CHUNK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WORD:1] a,
  input  logic [WORD:1] b,
  input  logic          bin,
  output logic          busy,
  output logic          done,
  output logic [WORD:1] diff,
  output logic          bout
);

  localparam int unsigned N     = WORD / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD-1:0]   a_q, a_d;
  logic [WORD-1:0]   b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [WORD-1:0]   diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  x_s, y_s, d_s;
  logic              bo_s;

  // Single slice subtractor, fed by the slice selected by the counter.
  assign x_s = a_q[cnt_q*CHUNK +: CHUNK];
  assign y_s = b_q[cnt_q*CHUNK +: CHUNK];

  sub_chunk #(.W(CHUNK)) u_sub (
    .x  (x_s),
    .y  (y_s),
    .bi (borrow_q),
    .d  (d_s),
    .bo (bo_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[cnt_q*CHUNK +: CHUNK] = d_s;
        borrow_d = bo_s;
        if (cnt_q == LAST) begin
          bout_d  = bo_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_seq_sub64.sv
module tb_seq_sub64;

  localparam int unsigned CHUNK = 16;
  localparam int          NSL   = 64 / CHUNK;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [64:1] a, b;
  logic        bin;
  logic        busy, done;
  logic [64:1] diff;
  logic        bout;

  int checks = 0;
  int errors = 0;

  seq_sub64 #(.CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] d;
    logic        bo;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [64:0] ref_sub(input logic [63:0] xa, input logic [63:0] xb,
                                         input logic xbin);
    logic [63:0] d;
    logic        bo;
    d  = xa - xb - 64'(xbin);
    bo = ({1'b0, xa} < ({1'b0, xb} + 65'(xbin)));
    return {bo, d};
  endfunction

  // Drive a start for one cycle; returns at the negedge after the accepting edge.
  task automatic launch(input logic [63:0] xa, input logic [63:0] xb, input logic xbin);
    @(negedge clk);
    a = xa; b = xb; bin = xbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); flags busy&done overlap.
  task automatic wait_done(output int edges, output logic overlap);
    edges   = 0;
    overlap = 1'b0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    end
  endtask

  task automatic do_op(input string name, input logic [63:0] xa, input logic [63:0] xb,
                       input logic xbin, input logic [63:0] ed, input logic eb);
    int   n;
    logic ov;
    launch(xa, xb, xbin);
    chk({name, "_busy"}, 64'(busy), 64'(1));
    wait_done(n, ov);
    chk({name, "_latency"}, 64'(n), 64'(NSL));
    chk({name, "_overlap"}, 64'(ov), 64'(0));
    chk({name, "_diff"}, diff, ed);
    chk({name, "_bout"}, 64'(bout), 64'(eb));
  endtask

  initial begin
    logic [64:0] r;
    logic [63:0] ra, rb;
    logic        rbin;
    int          n;
    logic        ov;
    logic        saw_done;

    vecs[0] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[1] = '{64'ha0041020021b00c0, 64'h0f010000100fda11, 1'b1, 64'h9103101ff20b26ae, 1'b0};
    vecs[2] = '{64'h0000000000010000, 64'h0000000000000001, 1'b0, 64'h000000000000ffff, 1'b0};
    vecs[3] = '{64'hffffffffffffffff, 64'hffffffffffffffff, 1'b1, 64'hffffffffffffffff, 1'b1};
    vecs[4] = '{64'h0, 64'h1, 1'b0, 64'hffffffffffffffff, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_diff", diff, 64'h0);
    chk("rst_bout", 64'(bout), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo);

    for (int i = 0; i < 25; i++) begin
      ra   = {$urandom(), $urandom()};
      rb   = (i % 5 == 0) ? ra : {$urandom(), $urandom()};
      rbin = 1'($urandom_range(0, 1));
      r    = ref_sub(ra, rb, rbin);
      do_op($sformatf("rnd%0d", i), ra, rb, rbin, r[63:0], r[64]);
    end

    // start pulsed mid-RUN is ignored; then start held through DONE.
    ra = 64'h123456789abcdef0; rb = 64'h0fedcba987654321;
    r  = ref_sub(ra, rb, 1'b0);
    launch(ra, rb, 1'b0);
    @(posedge clk); @(negedge clk);
    a = 64'hdeadbeefdeadbeef; b = 64'h1111111111111111; bin = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    wait_done(n, ov);
    chk("ignore_diff", diff, r[63:0]);
    chk("ignore_bout", 64'(bout), 64'(r[64]));
    r = ref_sub(64'hdeadbeefdeadbeef, 64'h1111111111111111, 1'b1);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_done_low", 64'(done), 64'(0));
    wait_done(n, ov);
    chk("b2b_latency", 64'(n), 64'(NSL));
    chk("b2b_diff", diff, r[63:0]);
    chk("b2b_bout", 64'(bout), 64'(r[64]));

    // Asynchronous reset two cycles into RUN.
    launch(64'hffff0000ffff0000, 64'h1, 1'b1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_diff", diff, 64'h0);
    chk("arst_bout", 64'(bout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("arst_no_done", 64'(saw_done), 64'(0));
    r = ref_sub(64'h8000000000000000, 64'h0000000000000001, 1'b0);
    do_op("after_rst", 64'h8000000000000000, 64'h1, 1'b0, r[63:0], r[64]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_sub64.md
# seq_sub64

Multi-cycle 64-bit subtractor computing diff = a − b − bin with borrow-out, processed one CHUNK-bit slice per clock, LSB slice first. It is the inverse-direction companion of the 64-bit adder datapath. It uses a start/busy/done handshake so that a sequencing controller can launch a subtraction and collect the result. Operand and result vectors use the same [64:1] bit numbering as the adder.

## Interface
- CHUNK, 16, bits processed per cycle; legal values 8, 16, 32, 64 (must divide 64)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a subtraction; sampled on the rising edge of clk
- a  input  [64:1]  minuend; latched when start is accepted
- b  input  [64:1]  subtrahend; latched when start is accepted
- bin  input  1  borrow-in; latched when start is accepted
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; diff and bout are valid
- diff  output  [64:1]  result a − b − bin, modulo 2^64
- bout  output  1  borrow-out: 1 when a < b + bin (unsigned)

## Operation
- States:
  - IDLE: reset state.
  - RUN: slice counter runs from 0 to N−1, where N = 64/CHUNK.
  - DONE: lasts one cycle.
- start accepted in IDLE or DONE:
  - Latches a, b and bin.
  - Clears the slice counter.
  - Moves to RUN.
- start in RUN is ignored. Operands are not re-latched and the current operation is unaffected.
- Each RUN cycle for slice k:
  - Computes the borrow-chain subtraction of a[(k+1)·CHUNK:k·CHUNK+1] − b[same] − borrow.
  - Writes the result into the matching slice of diff.
  - Registers the outgoing borrow.
  - For k = 0, the borrow-in is the latched bin.
- After slice N−1: bout = final borrow, state moves to DONE.
- DONE → IDLE next cycle if start is low; DONE → RUN if start is high (back-to-back operation).
- diff and bout hold their value from DONE until the next accepted start. While in RUN, diff slices not yet written retain their previous value and are not valid.
- Arithmetic is unsigned and wraps modulo 2^64. There is no overflow flag; signed overflow is the caller's concern.
- Reset (asynchronous, any state, including mid-RUN):
  - State → IDLE; operation aborted, no done pulse.
  - busy = 0, done = 0, diff = 0, bout = 0.
  - Internal operand registers and counter cleared.

## Timing
- start is high at edge t. busy rises after t. Slices are computed at edges t+1 … t+N. done is high for the cycle after t+N, and busy falls in that same cycle.
- Latency: N+1 edges from accepting start to done.
  - CHUNK = 16: N = 4, done is visible after edge t+4 (slice edges t+1 … t+4).
  - CHUNK = 64: N = 1, done is visible after edge t+1.
- busy and done are never high together.
- Throughput with start held high: one result every N+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package/header holds:
  - State encodings IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Width constant WORD = 64.
- One sub-module: sub_chunk.
  - Combinational CHUNK-bit borrow-ripple subtractor.
  - Ports: x, y, bi, d, bo.
  - Instantiated once and muxed by the slice counter.
- Top level holds the FSM, slice counter, operand registers, borrow register and result register.

## Test plan
- a = 0, b = 0, bin = 0 → diff = 0000000000000000, bout = 0; done exactly 5 cycles after start (CHUNK = 16).
- a = a0041020021b00c0, b = 0f010000100fda11, bin = 1 → diff = 9103101ff20b26ae, bout = 0.
- a = 0000000000010000, b = 0000000000000001, bin = 0 → diff = 000000000000ffff, bout = 0 (borrow crosses a slice boundary).
- a = ffffffffffffffff, b = ffffffffffffffff, bin = 1 → diff = ffffffffffffffff, bout = 1. Separately, a = 0, b = 1, bin = 0 → diff = ffffffffffffffff, bout = 1.
- Pulse start again 2 cycles into RUN with different operands → ignored; the first result is produced unchanged. Then hold start through DONE → second operation begins with no IDLE cycle.
- Assert rst 2 cycles into RUN → busy, done, diff and bout go to 0 immediately; no done pulse. A new start after rst is released completes normally.
